tagged_regfile_mcdb: RTL and testbench

//  Tomasulo architectural register file with per-register rename tag (label), generalised to
//  NUM_READ read ports and NUM_CDB common-data-bus broadcast channels, plus flush and busy count.

---
 rtl/tagged_regfile_mcdb_if.sv | 34 +++
 rtl/tagged_regfile_mcdb.sv | 143 ++++++++++++++
 tb/tb_tagged_regfile_mcdb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tagged_regfile_mcdb_if.sv
// Bus bundle for tagged_regfile_mcdb: read ports, rename port, CDB broadcast channels, flush, busy count.
// The master drives requests (issue logic / CDB arbiter); the slave is the register file.
interface tagged_regfile_mcdb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_READ = 2,
    parameter int NUM_CDB  = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic [NUM_READ*ADDR_W-1:0] ReadAddr;
    logic [NUM_READ*DATA_W-1:0] DataOut;
    logic [NUM_READ*TAG_W-1:0]  LabelOut;
    logic                       RegWr;
    logic [ADDR_W-1:0]          WriteAddr;
    logic [TAG_W-1:0]           WriteLabel;
    logic [NUM_CDB-1:0]         BCEN;
    logic [NUM_CDB*TAG_W-1:0]   BClabel;
    logic [NUM_CDB*DATA_W-1:0]  BCdata;
    logic                       Flush;
    logic [CNT_W-1:0]           BusyCount;

    modport master (
        output ReadAddr, RegWr, WriteAddr, WriteLabel, BCEN, BClabel, BCdata, Flush,
        input  DataOut, LabelOut, BusyCount
    );

    modport slave (
        input  ReadAddr, RegWr, WriteAddr, WriteLabel, BCEN, BClabel, BCdata, Flush,
        output DataOut, LabelOut, BusyCount
    );
endinterface

// File: rtl/tagged_regfile_mcdb.sv
// Tomasulo register file with rename labels, NUM_READ read ports and NUM_CDB broadcast channels.
// Define RF_CDB_BYPASS_EN to forward same-cycle CDB results onto the read ports.
module tagged_regfile_mcdb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_READ = 2,
    parameter int NUM_CDB  = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    tagged_regfile_mcdb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);
    localparam int MUX_N  = 1 << ADDR_W;

    logic [NUM_READ*ADDR_W-1:0] w_raddr;
    logic                       w_regwr;
    logic [ADDR_W-1:0]          w_waddr;
    logic [TAG_W-1:0]           w_wlabel;
    logic [NUM_CDB-1:0]         w_bcen;
    logic [NUM_CDB*TAG_W-1:0]   w_bclabel;
    logic [NUM_CDB*DATA_W-1:0]  w_bcdata;
    logic                       w_flush;

    assign w_raddr   = bus.ReadAddr;
    assign w_regwr   = bus.RegWr;
    assign w_waddr   = bus.WriteAddr;
    assign w_wlabel  = bus.WriteLabel;
    assign w_bcen    = bus.BCEN;
    assign w_bclabel = bus.BClabel;
    assign w_bcdata  = bus.BCdata;
    assign w_flush   = bus.Flush;

    // Read mux spans the full address space; unimplemented and r0 entries read as zero.
    logic [DATA_W-1:0] w_data_cur  [MUX_N];
    logic [TAG_W-1:0]  w_label_cur [MUX_N];
    logic [TAG_W-1:0]  w_label_next[NUM_REGS];
    logic [CNT_W-1:0]  w_busy_next;
    logic [CNT_W-1:0]  r_busy_count;

    // Returns {hit, data} for the lowest active channel carrying tag; tag 0 never hits.
    function automatic logic [DATA_W:0] bc_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        bcen,
        input logic [NUM_CDB*TAG_W-1:0]  bclabel,
        input logic [NUM_CDB*DATA_W-1:0] bcdata
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bcen[c] && tag != '0 && bclabel[c*TAG_W +: TAG_W] == tag) begin
                res = {1'b1, bcdata[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < MUX_N; gi++) begin : g_reg
            if (gi == 0 || gi >= NUM_REGS) begin : g_zero
                assign w_data_cur[gi]  = '0;
                assign w_label_cur[gi] = '0;
                if (gi < NUM_REGS) begin : g_r0
                    assign w_label_next[gi] = '0;
                end
            end else begin : g_live
                logic [DATA_W-1:0] r_data;
                logic [TAG_W-1:0]  r_label;
                logic [DATA_W-1:0] w_data_nx;
                logic [TAG_W-1:0]  w_label_nx;
                logic [DATA_W:0]   w_bc;

                assign w_bc = bc_lookup(r_label, w_bcen, w_bclabel, w_bcdata);

                // Flush beats rename; rename beats a broadcast aimed at the old label.
                always_comb begin
                    w_data_nx  = r_data;
                    w_label_nx = r_label;
                    if (w_flush) begin
                        w_label_nx = '0;
                    end else if (w_regwr && w_waddr == ADDR_W'(gi) && w_wlabel != '0) begin
                        w_label_nx = w_wlabel;
                    end else if (w_bc[DATA_W]) begin
                        w_data_nx  = w_bc[DATA_W-1:0];
                        w_label_nx = '0;
                    end
                end

                always_ff @(posedge clk or posedge RST) begin
                    if (RST) begin
                        r_data  <= '0;
                        r_label <= '0;
                    end else begin
                        r_data  <= w_data_nx;
                        r_label <= w_label_nx;
                    end
                end

                assign w_data_cur[gi]   = r_data;
                assign w_label_cur[gi]  = r_label;
                assign w_label_next[gi] = w_label_nx;
            end
        end
    endgenerate

    always_comb begin
        w_busy_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busy_next = w_busy_next + CNT_W'(w_label_next[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_busy_count <= '0;
        end else begin
            r_busy_count <= w_busy_next;
        end
    end

    assign bus.BusyCount = r_busy_count;

    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = w_raddr[gi*ADDR_W +: ADDR_W];
`ifdef RF_CDB_BYPASS_EN
            logic [DATA_W:0] w_byp;
            logic            w_use_byp;
            assign w_byp     = bc_lookup(w_label_cur[w_addr], w_bcen, w_bclabel, w_bcdata);
            assign w_use_byp = w_byp[DATA_W] && !w_flush;
            assign bus.DataOut[gi*DATA_W +: DATA_W] = w_use_byp ? w_byp[DATA_W-1:0] : w_data_cur[w_addr];
            assign bus.LabelOut[gi*TAG_W +: TAG_W]  = w_use_byp ? '0 : w_label_cur[w_addr];
`else
            assign bus.DataOut[gi*DATA_W +: DATA_W] = w_data_cur[w_addr];
            assign bus.LabelOut[gi*TAG_W +: TAG_W]  = w_label_cur[w_addr];
`endif
        end
    endgenerate
endmodule

// File: tb/tb_tagged_regfile_mcdb.sv
// Self-checking bench for tagged_regfile_mcdb: directed vector table, hand sequences, random vs model.
// Works in both builds; bypass-dependent expectations follow RF_CDB_BYPASS_EN.
module tb_tagged_regfile_mcdb;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int TW = 4;
    localparam int NRD = 2;
    localparam int NC = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic RST;
    int total = 0;
    int bad = 0;

    tagged_regfile_mcdb_if #(.DATA_W(DW), .NUM_REGS(NR), .TAG_W(TW), .NUM_READ(NRD), .NUM_CDB(NC)) bus ();

    tagged_regfile_mcdb #(.DATA_W(DW), .NUM_REGS(NR), .TAG_W(TW), .NUM_READ(NRD), .NUM_CDB(NC)) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Behavioural reference state
    logic [DW-1:0] m_data[NR];
    logic [TW-1:0] m_label[NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_data[i] = '0;
            m_label[i] = '0;
        end
    endtask

    function automatic int model_busy();
        int n = 0;
        for (int i = 0; i < NR; i++) if (m_label[i] != 0) n++;
        return n;
    endfunction

    // First channel (ascending) whose active tag equals tag; -1 if none
    function automatic int find_chan(input logic [TW-1:0] tag);
        for (int c = 0; c < NC; c++)
            if (tag != 0 && bus.BCEN[c] && bus.BClabel[c*TW +: TW] == tag) return c;
        return -1;
    endfunction

    task automatic model_update();
        if (bus.Flush) begin
            for (int i = 0; i < NR; i++) m_label[i] = '0;
        end else begin
            for (int i = 1; i < NR; i++) begin
                int c;
                c = find_chan(m_label[i]);
                if (bus.RegWr && int'(bus.WriteAddr) == i && bus.WriteLabel != 0) begin
                    m_label[i] = bus.WriteLabel;
                end else if (c >= 0) begin
                    m_data[i] = bus.BCdata[c*DW +: DW];
                    m_label[i] = '0;
                end
            end
        end
    endtask

    task automatic model_read(input int a, output logic [DW-1:0] d, output logic [TW-1:0] l);
        d = m_data[a];
        l = m_label[a];
`ifdef RF_CDB_BYPASS_EN
        if (!bus.Flush && a != 0) begin
            int c;
            c = find_chan(l);
            if (c >= 0) begin
                d = bus.BCdata[c*DW +: DW];
                l = '0;
            end
        end
`endif
    endtask

    task automatic set_idle();
        bus.RegWr = 1'b0;
        bus.WriteAddr = '0;
        bus.WriteLabel = '0;
        bus.BCEN = '0;
        bus.BClabel = '0;
        bus.BCdata = '0;
        bus.Flush = 1'b0;
    endtask

    task automatic clk_edge();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string name, input int k, input logic [DW-1:0] d, input logic [TW-1:0] l);
        check({name, "_data"}, 64'(bus.DataOut[k*DW +: DW]), 64'(d));
        check({name, "_label"}, 64'(bus.LabelOut[k*TW +: TW]), 64'(l));
    endtask

    typedef struct {
        logic          rw;
        logic [AW-1:0] wa;
        logic [TW-1:0] wl;
        logic [1:0]    bcen;
        logic [TW-1:0] bl1, bl0;
        logic [DW-1:0] bd1, bd0;
        logic          fl;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] d0;
        logic [TW-1:0] l0;
        logic [DW-1:0] d1;
        logic [TW-1:0] l1;
        logic [5:0]    busy;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        logic [DW-1:0] ed;
        logic [TW-1:0] el;

        // rw wa wl bcen bl1 bl0 bd1 bd0 fl | ra0 ra1 -> d0 l0 d1 l1 busy (state after the edge)
        vecs[0]  = '{1'b1, 5'd5,  4'd3, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd0, 32'h0, 4'd3, 32'h0, 4'd0, 6'd1};
        vecs[1]  = '{1'b0, 5'd0,  4'd0, 2'b10, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 4'd0, 32'hDEADBEEF, 4'd0, 6'd0};
        vecs[2]  = '{1'b1, 5'd2,  4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd2, 5'd7, 32'h0, 4'd4, 32'h0, 4'd0, 6'd1};
        vecs[3]  = '{1'b1, 5'd7,  4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd2, 5'd7, 32'h0, 4'd4, 32'h0, 4'd4, 6'd2};
        vecs[4]  = '{1'b0, 5'd0,  4'd0, 2'b11, 4'd4, 4'd4, 32'h22, 32'h11, 1'b0, 5'd2, 5'd7, 32'h11, 4'd0, 32'h11, 4'd0, 6'd0};
        vecs[5]  = '{1'b1, 5'd9,  4'd6, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd9, 5'd5, 32'h0, 4'd6, 32'hDEADBEEF, 4'd0, 6'd1};
        vecs[6]  = '{1'b1, 5'd9,  4'd8, 2'b01, 4'd0, 4'd6, 32'h0, 32'h99, 1'b0, 5'd9, 5'd9, 32'h0, 4'd8, 32'h0, 4'd8, 6'd1};
        vecs[7]  = '{1'b0, 5'd0,  4'd0, 2'b01, 4'd0, 4'd8, 32'h0, 32'h55, 1'b0, 5'd9, 5'd2, 32'h55, 4'd0, 32'h11, 4'd0, 6'd0};
        vecs[8]  = '{1'b1, 5'd1,  4'd1, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 32'h0, 4'd1, 32'h11, 4'd0, 6'd1};
        vecs[9]  = '{1'b1, 5'd2,  4'd2, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd2, 5'd3, 32'h11, 4'd2, 32'h0, 4'd0, 6'd2};
        vecs[10] = '{1'b1, 5'd3,  4'd3, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd4, 32'h0, 4'd3, 32'h0, 4'd0, 6'd3};
        vecs[11] = '{1'b1, 5'd4,  4'd5, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd4, 5'd1, 32'h0, 4'd5, 32'h0, 4'd1, 6'd4};
        vecs[12] = '{1'b1, 5'd6,  4'd7, 2'b01, 4'd0, 4'd1, 32'h0, 32'h77, 1'b1, 5'd1, 5'd6, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0};
        vecs[13] = '{1'b1, 5'd0,  4'd5, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0};
        vecs[14] = '{1'b1, 5'd10, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd10, 5'd10, 32'h0, 4'd0, 32'h0, 4'd0, 6'd0};
        vecs[15] = '{1'b0, 5'd0,  4'd0, 2'b01, 4'd0, 4'd0, 32'h0, 32'hAB, 1'b0, 5'd5, 5'd10, 32'hDEADBEEF, 4'd0, 32'h0, 4'd0, 6'd0};
        vecs[16] = '{1'b1, 5'd11, 4'd9, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd11, 5'd0, 32'h0, 4'd9, 32'h0, 4'd0, 6'd1};
        vecs[17] = '{1'b0, 5'd0,  4'd0, 2'b11, 4'd9, 4'd2, 32'hBBBB, 32'hAAAA, 1'b0, 5'd11, 5'd2, 32'hBBBB, 4'd0, 32'h11, 4'd0, 6'd0};

        // Power-on reset
        RST = 1'b1;
        set_idle();
        bus.ReadAddr = {5'd5, 5'd0};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_port("reset_p0", 0, '0, '0);
        check_port("reset_p1", 1, '0, '0);
        check("reset_busy", 64'(bus.BusyCount), 64'd0);
        RST = 1'b0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            bus.RegWr = vecs[i].rw;
            bus.WriteAddr = vecs[i].wa;
            bus.WriteLabel = vecs[i].wl;
            bus.BCEN = vecs[i].bcen;
            bus.BClabel = {vecs[i].bl1, vecs[i].bl0};
            bus.BCdata = {vecs[i].bd1, vecs[i].bd0};
            bus.Flush = vecs[i].fl;
            clk_edge();
            set_idle();
            bus.ReadAddr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check_port($sformatf("vec%0d_p0", i), 0, vecs[i].d0, vecs[i].l0);
            check_port($sformatf("vec%0d_p1", i), 1, vecs[i].d1, vecs[i].l1);
            check($sformatf("vec%0d_busy", i), 64'(bus.BusyCount), 64'(vecs[i].busy));
            $display("vec %0d: rw=%0b wa=%0d wl=%0d bcen=%b fl=%0b busy=%0d", i, vecs[i].rw,
                     vecs[i].wa, vecs[i].wl, vecs[i].bcen, vecs[i].fl, bus.BusyCount);
        end

        // Hand sequence: flush suppresses bypass, then same-cycle bypass with concurrent rename
        bus.ReadAddr = {5'd5, 5'd5};
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd5; bus.WriteLabel = 4'd3;
        clk_edge();
        set_idle();
        bus.Flush = 1'b1; bus.BCEN = 2'b10; bus.BClabel = {4'd3, 4'd0}; bus.BCdata = {32'h1111, 32'h0};
        #1;
        check_port("flush_nobyp", 0, 32'hDEADBEEF, 4'd3);
        $display("seq flush+broadcast on r5 tag 3");
        clk_edge();
        set_idle();
        #1;
        check_port("flush_after", 1, 32'hDEADBEEF, 4'd0);
        check("flush_busy", 64'(bus.BusyCount), 64'd0);
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd5; bus.WriteLabel = 4'd3;
        clk_edge();
        bus.WriteLabel = 4'd7;
        bus.BCEN = 2'b10; bus.BClabel = {4'd3, 4'd0}; bus.BCdata = {32'h0BADF00D, 32'h0};
        #1;
`ifdef RF_CDB_BYPASS_EN
        check_port("bypass_p0", 0, 32'h0BADF00D, 4'd0);
        check_port("bypass_p1", 1, 32'h0BADF00D, 4'd0);
`else
        check_port("nobypass_p0", 0, 32'hDEADBEEF, 4'd3);
        check_port("nobypass_p1", 1, 32'hDEADBEEF, 4'd3);
`endif
        $display("seq broadcast tag 3 with rename r5->7 same cycle");
        clk_edge();
        set_idle();
        #1;
        check_port("rename_wins", 0, 32'hDEADBEEF, 4'd7);
        check("rename_wins_busy", 64'(bus.BusyCount), 64'd1);
        bus.BCEN = 2'b01; bus.BClabel = {4'd0, 4'd7}; bus.BCdata = {32'h0, 32'hCAFE};
        clk_edge();
        set_idle();
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd5; bus.WriteLabel = 4'd4;
        clk_edge();
        set_idle();
        bus.ReadAddr = {5'd2, 5'd5};
        #1;
        check_port("pre_rst_r5", 0, 32'hCAFE, 4'd4);
        check_port("pre_rst_r2", 1, 32'h11, 4'd0);
        check("pre_rst_busy", 64'(bus.BusyCount), 64'd1);

        // Mid-cycle asynchronous reset
        #1;
        RST = 1'b1;
        #1;
        check_port("async_rst_p0", 0, '0, '0);
        check_port("async_rst_p1", 1, '0, '0);
        check("async_rst_busy", 64'(bus.BusyCount), 64'd0);
        $display("seq async reset mid-cycle");
        #2;
        RST = 1'b0;
        model_reset();
        clk_edge();

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a0, a1;
            logic [TW-1:0] t0, t1;
            bus.RegWr = ($urandom_range(0, 9) < 6);
            bus.WriteAddr = AW'($urandom_range(0, NR - 1));
            bus.WriteLabel = TW'($urandom_range(0, 15));
            bus.BCEN = 2'($urandom_range(0, 3));
            t0 = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 15)) : m_label[$urandom_range(0, NR - 1)];
            t1 = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 15)) : m_label[$urandom_range(0, NR - 1)];
            bus.BClabel = {t1, t0};
            bus.BCdata = {$urandom(), $urandom()};
            bus.Flush = ($urandom_range(0, 39) == 0);
            a0 = AW'($urandom_range(0, NR - 1));
            a1 = AW'($urandom_range(0, NR - 1));
            bus.ReadAddr = {a1, a0};
            #2;
            model_read(int'(a0), ed, el);
            check_port($sformatf("rnd%0d_p0", n), 0, ed, el);
            model_read(int'(a1), ed, el);
            check_port($sformatf("rnd%0d_p1", n), 1, ed, el);
            check($sformatf("rnd%0d_busy", n), 64'(bus.BusyCount), 64'(model_busy()));
            $display("rnd %0d: rw=%0b wa=%0d wl=%0d bcen=%b bl=%0d/%0d fl=%0b ra=%0d/%0d busy=%0d",
                     n, bus.RegWr, bus.WriteAddr, bus.WriteLabel, bus.BCEN, t1, t0, bus.Flush,
                     a1, a0, bus.BusyCount);
            clk_edge();
        end
        set_idle();
        #1;
        check("final_busy", 64'(bus.BusyCount), 64'(model_busy()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
